lfsr_range_gen: RTL

- Parametrised successor to the fixed 14-bit LFSR wait-time generator.
- Free-running Fibonacci LFSR with configurable width, tap mask and seed. Software/FSM seed reload is supported.
- On a request handshake, a sequential shift-subtract unit reduces a captured sample into [LOWER, LOWER+SPAN-1]. This replaces the combinational modulo.
- Feeds the random wait-time value to the reaction-timer control FSM.

---
 rtl/lfsr_range_gen.sv | 130 +++++++++++++
 1 files changed

// File: rtl/lfsr_range_gen.sv
// rtl/lfsr_range_gen.sv - free-running Fibonacci LFSR with a sequential range reducer
// A request captures the LFSR state and maps it into [LOWER, LOWER+SPAN-1] one bit per clock.
module lfsr_range_gen #(
  parameter int                WIDTH        = 16,
  parameter logic [WIDTH-1:0]  TAPS         = 16'h100B,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = 16'hACE1,
  parameter int                OUT_W        = 14,
  parameter int                LOWER        = 1000,
  parameter int                SPAN         = 4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] value,
  output logic [WIDTH-1:0] rnd_out
);

  localparam int                REM_W    = $clog2(SPAN) + 1;
  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [REM_W:0]    SPAN_T   = (REM_W+1)'(SPAN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [OUT_W-1:0]  LOWER_T  = OUT_W'(LOWER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDUCE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_rnd;
  logic [WIDTH-1:0] r_dividend;
  logic [REM_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic [OUT_W-1:0] r_value;
  logic             w_fb;
  logic             w_capture;
  logic [REM_W:0]   w_t;
  logic [REM_W-1:0] w_rem_nxt;

  assign w_fb = ^(r_rnd & TAPS);

  // A zero seed is replaced so the LFSR can never lock up in the all-zero state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rnd <= DEFAULT_SEED;
    end else if (seed_load) begin
      r_rnd <= (seed_in == '0) ? DEFAULT_SEED : seed_in;
    end else if (enable) begin
      r_rnd <= {w_fb, r_rnd[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_capture   = 1'b1;
          w_state_nxt = S_REDUCE;
        end
      end
      S_REDUCE: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Restoring-division step: the remainder stays below SPAN, so t stays below 2*SPAN.
  assign w_t       = {r_rem, r_dividend[WIDTH-1]};
  assign w_rem_nxt = (w_t >= SPAN_T) ? REM_W'(w_t - SPAN_T) : REM_W'(w_t);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dividend <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_value    <= LOWER_T;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_dividend <= r_rnd;
            r_rem      <= '0;
            r_cnt      <= '0;
          end
        end
        S_REDUCE: begin
          r_rem      <= w_rem_nxt;
          r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
          r_cnt      <= r_cnt + CNT_W'(1);
        end
        S_DONE: begin
          r_value <= LOWER_T + OUT_W'(r_rem);
          r_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign valid   = r_valid;
  assign value   = r_value;
  assign rnd_out = r_rnd;

endmodule
